// File: rtl/hazard_ctrl_seq_if.sv
// hazard_ctrl_seq_if: ID/EX hazard inputs and pipeline-control outputs
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_seq_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  logic [AW-1:0]    rs1_id;
  logic [AW-1:0]    rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic [AW-1:0]    rd_ex;
  logic             load_ex;
  logic             branch_id;
  logic             branch_taken_ex;
  logic             stall_pc;
  logic             stall_ifid;
  logic             bubble_idex;
  logic             kill_ifid;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    output rd_ex, load_ex, branch_id, branch_taken_ex,
    input  stall_pc, stall_ifid, bubble_idex, kill_ifid,
    input  busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    input  rd_ex, load_ex, branch_id, branch_taken_ex,
    output stall_pc, stall_ifid, bubble_idex, kill_ifid,
    output busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: sequential load-use / branch hazard controller.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl_seq #(
  parameter int AW           = 5,
  parameter int LOAD_USE_CYC = 1,
  parameter int BR_WAIT_CYC  = 1,
  parameter int CNT_W        = 32
) (
  input logic clk,
  input logic reset,
  hazard_ctrl_seq_if.slave hif
);

  typedef enum logic [1:0] {
    IDLE,
    LDSTALL,
    BRWAIT,
    BRRES
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_CYC - 1);
  localparam logic [2:0] BR_INIT = 3'(BR_WAIT_CYC - 1);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       hz;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       st_pc;
  logic       st_ifid;
  logic       bub;
  logic       kill;
  logic       bsy;

  // x0 and unused operands never produce a hazard
  always_comb begin
    rs1_hit = hif.rs1_used_id & (hif.rs1_id == hif.rd_ex);
    rs2_hit = hif.rs2_used_id & (hif.rs2_id == hif.rd_ex);
    hz = hif.load_ex & (hif.rd_ex != '0)
       & (rs1_hit | rs2_hit);
  end

  // state and bubble counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: load-use wins over branch in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz) begin
          if (LOAD_USE_CYC > 1) begin
            state_d = LDSTALL;
            cnt_d   = LU_INIT;
          end
        end else if (hif.branch_id) begin
          if (BR_WAIT_CYC > 1) begin
            state_d = BRWAIT;
            cnt_d   = BR_INIT;
          end else begin
            state_d = BRRES;
          end
        end
      end
      LDSTALL: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = IDLE;
      end
      BRWAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = BRRES;
      end
      BRRES: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // control outputs: zero-cycle response in IDLE, forced off in reset
  always_comb begin
    st_pc   = 1'b0;
    st_ifid = 1'b0;
    bub     = 1'b0;
    kill    = 1'b0;
    bsy     = 1'b0;
    if (!reset) begin
      bsy = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (hz) begin
            st_pc   = 1'b1;
            st_ifid = 1'b1;
            bub     = 1'b1;
          end else if (hif.branch_id) begin
            st_pc = 1'b1;
            kill  = 1'b1;
          end
        end
        LDSTALL: begin
          st_pc   = 1'b1;
          st_ifid = 1'b1;
          bub     = 1'b1;
        end
        BRWAIT: begin
          st_pc = 1'b1;
          kill  = 1'b1;
        end
        BRRES: begin
          kill = hif.branch_taken_ex;
        end
        default: begin
          bsy = 1'b0;
        end
      endcase
    end
  end

  assign hif.stall_pc    = st_pc;
  assign hif.stall_ifid  = st_ifid;
  assign hif.bubble_idex = bub;
  assign hif.kill_ifid   = kill;
  assign hif.busy        = bsy;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             flush_ev;

  assign flush_ev = (state_q == BRRES) & hif.branch_taken_ex;

  // free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (st_pc) stall_q <= stall_q + 1'b1;
      if (flush_ev) flush_q <= flush_q + 1'b1;
    end
  end

  assign hif.stall_cnt = reset ? '0 : stall_q;
  assign hif.flush_cnt = reset ? '0 : flush_q;
`else
  assign hif.stall_cnt = '0;
  assign hif.flush_cnt = '0;
`endif

endmodule
